// File: rtl/spram_arb_if.sv
// Bus bundle between the two requesters, the spram_arb arbiter and the single-port RAM.
// The slave modport is the arbiter's view; the master modport is the requester/RAM side.
interface spram_arb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 256
);
    localparam int AW = $clog2(DATA_DEPTH);

    logic [1:0]              req_valid;
    logic [1:0]              req_wr;
    logic [2*AW-1:0]         req_addr;
    logic [2*DATA_WIDTH-1:0] req_wdata;
    logic [1:0]              req_ready;
    logic [1:0]              rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    ram_en;
    logic                    ram_wr_en;
    logic [AW-1:0]           ram_addr;
    logic [DATA_WIDTH-1:0]   ram_wr_data;
    logic [DATA_WIDTH-1:0]   ram_rd_data;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, ram_rd_data,
        output req_ready, rsp_valid, rsp_rdata, ram_en, ram_wr_en, ram_addr, ram_wr_data
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, ram_rd_data,
        input  req_ready, rsp_valid, rsp_rdata, ram_en, ram_wr_en, ram_addr, ram_wr_data
    );
endinterface

// File: rtl/spram_arb.sv
// Two-requester arbiter in front of a single-port RAM with one-cycle read latency.
// Define SPRAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module spram_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 256
) (
    input  logic      clk,
    input  logic      rst,
    spram_arb_if.slave bus
);
    localparam int AW = $clog2(DATA_DEPTH);

    logic [1:0]            w_grant;
    logic                  w_accept;
    logic                  w_gid;
    logic                  w_sel_wr;
    logic [AW-1:0]         w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  r_rd_pending;
    logic                  r_rd_id;
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
    logic                  r_last_grant;
`endif

    // Grant selection: single requester wins outright, ties use the configured policy.
    always_comb begin
        w_grant = 2'b00;
        if (rst) begin
            w_grant = 2'b00;
        end else begin
            case (bus.req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
                2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
`else
                2'b11:   w_grant = 2'b01;
`endif
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_accept      = |w_grant;
    assign w_gid         = w_grant[1];
    assign w_sel_wr      = w_gid ? bus.req_wr[1] : bus.req_wr[0];
    assign w_sel_addr    = w_gid ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
    assign w_sel_wdata   = w_gid ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : bus.req_wdata[DATA_WIDTH-1:0];
    assign bus.req_ready = w_grant;

    // RAM port mux: granted requester drives the RAM, everything is zero otherwise.
    always_comb begin
        bus.ram_en      = 1'b0;
        bus.ram_wr_en   = 1'b0;
        bus.ram_addr    = {AW{1'b0}};
        bus.ram_wr_data = {DATA_WIDTH{1'b0}};
        if (w_accept) begin
            bus.ram_en      = 1'b1;
            bus.ram_wr_en   = w_sel_wr;
            bus.ram_addr    = w_sel_addr;
            bus.ram_wr_data = w_sel_wdata;
        end else begin
            bus.ram_en      = 1'b0;
        end
    end

    // Outstanding-read tracking and last-grant history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pending <= 1'b0;
            r_rd_id      <= 1'b0;
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_rd_pending <= w_accept & ~w_sel_wr;
            if (w_accept && !w_sel_wr) begin
                r_rd_id <= w_gid;
            end else begin
                r_rd_id <= r_rd_id;
            end
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
            if (w_accept) begin
                r_last_grant <= w_gid;
            end else begin
                r_last_grant <= r_last_grant;
            end
`endif
        end
    end

    // Response strobe comes from the pending register; masking with rst kills a
    // response that would otherwise land in the first reset cycle.
    always_comb begin
        bus.rsp_valid = 2'b00;
        bus.rsp_rdata = {DATA_WIDTH{1'b0}};
        if (r_rd_pending && !rst) begin
            bus.rsp_valid = r_rd_id ? 2'b10 : 2'b01;
            bus.rsp_rdata = bus.ram_rd_data;
        end else begin
            bus.rsp_valid = 2'b00;
        end
    end
endmodule
